// File: rtl/ahb_irq_ctrl.sv
// AHB-Lite interrupt controller: synchronised sources, level/edge pending logic,
// enable masking and a small zero-wait-state register file.
module ahb_irq_ctrl #(
    parameter int NUM_SRC     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               HSEL,
    input  logic [31:0]        HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [31:0]        HWDATA,
    input  logic               HREADY,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               HRESP,
    input  logic [NUM_SRC-1:0] SRC,
    output logic [31:0]        IRQ
);

    localparam logic [2:0] OFF_ENABLE  = 3'd0;
    localparam logic [2:0] OFF_MODE    = 3'd1;
    localparam logic [2:0] OFF_PENDING = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_SWSET   = 3'd4;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] sync_out;
    logic [NUM_SRC-1:0] dly_q;
    logic [NUM_SRC-1:0] rise;

    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] swset;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] rd_val;

    logic               ap_valid;
    logic               dp_valid_q;
    logic               dp_write_q;
    logic               dp_size_ok_q;
    logic [2:0]         dp_addr_q;
    logic               wr_en;
    logic               unused_bits;

    assign HREADYOUT   = 1'b1;
    assign HRESP       = 1'b0;
    assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    assign ap_valid = HSEL & HREADY & HTRANS[1];
    assign wr_en    = dp_valid_q & dp_write_q & dp_size_ok_q;
    assign wdata    = HWDATA[NUM_SRC-1:0];
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~dly_q;

    // Per-source synchroniser chain; the delay flop follows the last stage
    // regardless of mode, so switching to edge mode never fakes an edge.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            dly_q <= '0;
        end else begin
            sync_q[0] <= SRC;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            dly_q <= sync_out;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_valid_q   <= 1'b0;
            dp_write_q   <= 1'b0;
            dp_size_ok_q <= 1'b0;
            dp_addr_q    <= '0;
        end else begin
            dp_valid_q <= ap_valid;
            if (ap_valid) begin
                dp_write_q   <= HWRITE;
                dp_size_ok_q <= (HSIZE == 3'b010);
                dp_addr_q    <= HADDR[4:2];
            end
        end
    end

    // Set sources are ORed after the clear term, so a same-cycle set beats W1C.
    always_comb begin
        w1c       = '0;
        swset     = '0;
        pending_d = '0;
        if (wr_en && (dp_addr_q == OFF_PENDING)) begin
            w1c = wdata;
        end
        if (wr_en && (dp_addr_q == OFF_SWSET)) begin
            swset = wdata;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i]) begin
                pending_d[i] = (pending_q[i] & ~w1c[i]) | rise[i] | swset[i];
            end else begin
                pending_d[i] = sync_out[i];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            irq_q     <= '0;
        end else begin
            if (wr_en && (dp_addr_q == OFF_ENABLE)) begin
                enable_q <= wdata;
            end
            if (wr_en && (dp_addr_q == OFF_MODE)) begin
                mode_q <= wdata;
            end
            pending_q <= pending_d;
            irq_q     <= pending_q & enable_q;
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (dp_addr_q)
            OFF_ENABLE:  rd_val = enable_q;
            OFF_MODE:    rd_val = mode_q;
            OFF_PENDING: rd_val = pending_q;
            OFF_STATUS:  rd_val = pending_q & enable_q;
            default:     rd_val = '0;
        endcase
        HRDATA = '0;
        if (dp_valid_q && !dp_write_q) begin
            HRDATA[NUM_SRC-1:0] = rd_val;
        end
    end

    always_comb begin
        IRQ = '0;
        IRQ[NUM_SRC-1:0] = irq_q;
    end

endmodule

// File: tb/tb_ahb_irq_ctrl.sv
// Bench for ahb_irq_ctrl (NUM_SRC=8): register-map vector table, directed
// latency/corner sequences and a randomised run against a reference model.
module tb_ahb_irq_ctrl;

    localparam int NS = 8;
    localparam int SS = 2;

    logic          HCLK;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [NS-1:0] SRC;
    logic [31:0]   IRQ;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    bit [7:0]   m_en, m_mode, m_pend, m_irq;
    bit         m_dvalid, m_dwrite, m_dsz;
    bit [2:0]   m_daddr;
    logic [7:0] hist[$];

    ahb_irq_ctrl #(.NUM_SRC(NS), .SYNC_STAGES(SS)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .SRC(SRC), .IRQ(IRQ)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic busIdle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = '0;
        HSIZE  = 3'b010;
        HREADY = 1'b1;
    endtask

    task automatic doReset();
        HRESET = 1'b1;
        busIdle();
        HWDATA = '0;
        SRC    = '0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
    endtask

    // All bus tasks start and end one time unit after a rising edge.
    task automatic ahbWrite(logic [31:0] addr, logic [31:0] data, logic [2:0] size);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr; HSIZE = size; HREADY = 1'b1;
        @(posedge HCLK); #1;
        busIdle();
        HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic ahbRead(logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr; HSIZE = 3'b010; HREADY = 1'b1;
        @(posedge HCLK); #1;
        busIdle();
        data = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic addVec(bit wr, logic [31:0] addr, logic [31:0] data, logic [2:0] size, logic [31:0] exp);
        vecs.push_back('{wr, addr, data, size, exp});
    endtask

    task automatic modelReset();
        m_en = '0; m_mode = '0; m_pend = '0; m_irq = '0;
        m_dvalid = 1'b0; m_dwrite = 1'b0; m_dsz = 1'b0; m_daddr = '0;
        hist.delete();
        for (int k = 0; k < SS + 2; k++) hist.push_back(8'h00);
    endtask

    // Called right at a rising edge: inputs are still those seen by that edge.
    task automatic modelEdge();
        bit [7:0] lvl, prv, w1c, sws, en_n, mode_n, pend_n;
        int last;
        hist.push_back(SRC);
        last = hist.size() - 1;
        lvl  = hist[last-SS];
        prv  = hist[last-SS-1];
        w1c = '0; sws = '0; en_n = m_en; mode_n = m_mode;
        if (m_dvalid && m_dwrite && m_dsz) begin
            case (m_daddr)
                3'd0: en_n   = HWDATA[7:0];
                3'd1: mode_n = HWDATA[7:0];
                3'd2: w1c    = HWDATA[7:0];
                3'd4: sws    = HWDATA[7:0];
                default: ;
            endcase
        end
        for (int i = 0; i < NS; i++) begin
            if (!m_mode[i])
                pend_n[i] = lvl[i];
            else if ((lvl[i] && !prv[i]) || sws[i])
                pend_n[i] = 1'b1;
            else if (w1c[i])
                pend_n[i] = 1'b0;
            else
                pend_n[i] = m_pend[i];
        end
        m_irq    = m_pend & m_en;
        m_en     = en_n;
        m_mode   = mode_n;
        m_pend   = pend_n;
        m_dvalid = HSEL && HREADY && HTRANS[1];
        if (m_dvalid) begin
            m_dwrite = HWRITE;
            m_dsz    = (HSIZE == 3'b010);
            m_daddr  = HADDR[4:2];
        end
        if (hist.size() > 16) void'(hist.pop_front());
    endtask

    function automatic logic [31:0] modelRead(bit [2:0] off);
        case (off)
            3'd0:    return {24'h0, m_en};
            3'd1:    return {24'h0, m_mode};
            3'd2:    return {24'h0, m_pend};
            3'd3:    return {24'h0, m_pend & m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic applyStimulus();
        logic [31:0] rd;
        logic [31:0] rnd;

        // Reset state and register map table
        doReset();
        checkOutput("rst_irq", IRQ, 32'h0);
        checkOutput("rst_hrdata", HRDATA, 32'h0);
        checkOutput("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        checkOutput("rst_hresp", {31'h0, HRESP}, 32'h0);

        addVec(1, 32'h00, 32'hFFFF_FFFF, 3'b010, 32'h0);
        addVec(0, 32'h00, 32'h0,         3'b010, 32'h0000_00FF);
        addVec(1, 32'h00, 32'h0000_0012, 3'b000, 32'h0);
        addVec(0, 32'h00, 32'h0,         3'b010, 32'h0000_00FF);
        addVec(0, 32'h1C, 32'h0,         3'b010, 32'h0);
        addVec(1, 32'h04, 32'h0000_00A5, 3'b010, 32'h0);
        addVec(0, 32'h04, 32'h0,         3'b010, 32'h0000_00A5);
        addVec(1, 32'h14, 32'hFFFF_FFFF, 3'b010, 32'h0);
        addVec(0, 32'h14, 32'h0,         3'b010, 32'h0);
        addVec(0, 32'h08, 32'h0,         3'b010, 32'h0);
        addVec(1, 32'h10, 32'h0000_00FF, 3'b010, 32'h0);
        addVec(0, 32'h10, 32'h0,         3'b010, 32'h0);
        addVec(0, 32'h08, 32'h0,         3'b010, 32'h0000_00A5);
        addVec(0, 32'h0C, 32'h0,         3'b010, 32'h0000_00A5);
        addVec(1, 32'h08, 32'h0000_0005, 3'b010, 32'h0);
        addVec(0, 32'h08, 32'h0,         3'b010, 32'h0000_00A0);
        addVec(1, 32'h00, 32'h0000_0030, 3'b010, 32'h0);
        addVec(0, 32'h0C, 32'h0,         3'b010, 32'h0000_0020);
        addVec(1, 32'h08, 32'h0000_00FF, 3'b001, 32'h0);
        addVec(0, 32'h08, 32'h0,         3'b010, 32'h0000_00A0);

        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].wr) begin
                ahbWrite(vecs[v].addr, vecs[v].data, vecs[v].size);
            end else begin
                ahbRead(vecs[v].addr, rd);
                checkOutput($sformatf("vec%0d_rd", v), rd, vecs[v].exp);
            end
        end

        // Write then read of ENABLE back to back, no idle cycle between
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HWRITE = 1'b0; HWDATA = 32'h0000_003C;
        @(posedge HCLK); #1;
        busIdle();
        checkOutput("b2b_rd", HRDATA, 32'h0000_003C);
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("irq_after_table", IRQ, 32'h0000_0020);

        // Level channel latency
        doReset();
        ahbWrite(32'h00, 32'h1, 3'b010);
        ahbWrite(32'h04, 32'h0, 3'b010);
        SRC = 8'h01;
        for (int k = 1; k <= 4; k++) begin
            @(posedge HCLK); #1;
            checkOutput($sformatf("lvl_rise_e%0d", k), IRQ, (k >= 4) ? 32'h1 : 32'h0);
        end
        SRC = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            @(posedge HCLK); #1;
            checkOutput($sformatf("lvl_fall_e%0d", k), IRQ, (k >= 4) ? 32'h0 : 32'h1);
        end

        // Edge channel pulse, sticky pending, W1C
        ahbWrite(32'h04, 32'h2, 3'b010);
        ahbWrite(32'h00, 32'h2, 3'b010);
        SRC = 8'h02;
        repeat (3) @(posedge HCLK);
        #1 SRC = 8'h00;
        repeat (5) @(posedge HCLK);
        #1;
        ahbRead(32'h08, rd);
        checkOutput("edge_pend_set", rd, 32'h2);
        repeat (4) @(posedge HCLK);
        #1;
        ahbRead(32'h08, rd);
        checkOutput("edge_pend_sticky", rd, 32'h2);
        checkOutput("edge_irq_on", IRQ, 32'h2);
        ahbWrite(32'h08, 32'h2, 3'b010);
        checkOutput("w1c_irq_same", IRQ, 32'h2);
        @(posedge HCLK); #1;
        checkOutput("w1c_irq_next", IRQ, 32'h0);
        ahbRead(32'h08, rd);
        checkOutput("w1c_pend", rd, 32'h0);

        // New edge arrives in the same cycle as a W1C of that bit
        SRC = 8'h02;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h08; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        busIdle();
        HWDATA = 32'h2;
        @(posedge HCLK); #1;
        ahbRead(32'h08, rd);
        checkOutput("set_beats_clr", rd, 32'h2);

        // SWSET only affects edge channels
        SRC = 8'h00;
        repeat (4) @(posedge HCLK);
        #1;
        ahbWrite(32'h04, 32'h1, 3'b010);
        ahbWrite(32'h00, 32'h3, 3'b010);
        ahbWrite(32'h10, 32'h3, 3'b010);
        ahbRead(32'h08, rd);
        checkOutput("swset_pend", rd, 32'h1);
        ahbRead(32'h0C, rd);
        checkOutput("swset_status", rd, 32'h1);

        // Randomised run against the reference model
        doReset();
        modelReset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) SRC = NS'($urandom);
            rnd    = $urandom;
            HWDATA = $urandom;
            HREADY = m_dvalid ? 1'b1 : ($urandom_range(0, 3) != 0);
            HSEL   = ($urandom_range(0, 3) != 0);
            HTRANS = 2'($urandom_range(0, 3));
            HWRITE = rnd[0];
            HSIZE  = (rnd[1] && rnd[2]) ? 3'($urandom_range(0, 7)) : 3'b010;
            HADDR  = {rnd[31:5], 3'($urandom_range(0, 7)), 2'b00};
            @(posedge HCLK);
            modelEdge();
            #1;
            checkOutput($sformatf("rnd_irq_c%0d", c), IRQ, {24'h0, m_irq});
            if (m_dvalid && !m_dwrite)
                checkOutput($sformatf("rnd_rd_c%0d", c), HRDATA, modelRead(m_daddr));
        end
        busIdle();

        // Asynchronous reset with all lines asserted
        doReset();
        ahbWrite(32'h00, 32'hFF, 3'b010);
        SRC = 8'hFF;
        repeat (6) @(posedge HCLK);
        #1;
        checkOutput("pre_areset_irq", IRQ, 32'h0000_00FF);
        @(negedge HCLK);
        #2 HRESET = 1'b1;
        #1;
        checkOutput("areset_irq", IRQ, 32'h0);
        checkOutput("areset_hrdata", HRDATA, 32'h0);
        checkOutput("areset_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        SRC = 8'h00;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        ahbRead(32'h00, rd);
        checkOutput("areset_enable", rd, 32'h0);
        ahbRead(32'h08, rd);
        checkOutput("areset_pending", rd, 32'h0);
    endtask

    initial begin
        HRESET = 1'b1;
        busIdle();
        HWDATA = '0;
        SRC    = '0;
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_irq_ctrl.md
AHB_IRQ_CTRL -- requirements
Module: ahb_irq_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 32, number of interrupt sources (legal range 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser depth per source (legal range 2..4).
REQ-003 HCLK  input  1  single clock; all state changes on its rising edge.
REQ-004 HRESET  input  1  asynchronous, active-high reset.
REQ-005 HSEL  input  1  AHB-Lite slave select.
REQ-006 HADDR  input  32  AHB address; only bits [4:2] are decoded.
REQ-007 HTRANS  input  2  AHB transfer type; NONSEQ/SEQ count as active.
REQ-008 HWRITE  input  1  write when high.
REQ-009 HSIZE  input  3  transfer size.
REQ-010 HWDATA  input  32  write data, valid in the data phase.
REQ-011 HREADY  input  1  bus-wide ready; the address phase is sampled only when high.
REQ-012 HRDATA  output  32  read data, valid in the data phase.
REQ-013 HREADYOUT  output  1  slave ready; constant 1 (zero wait state).
REQ-014 HRESP  output  1  constant 0 (OKAY).
REQ-015 SRC  input  NUM_SRC  asynchronous interrupt sources.
REQ-016 IRQ  output  32  registered interrupt lines to the core; bits [31:NUM_SRC] tied 0.

Function
REQ-017 Each SRC bit shall pass through a SYNC_STAGES-deep flop chain before any other use.
REQ-018 Register map (word offsets): 0x00 ENABLE RW; 0x04 MODE RW (1 = rising edge, 0 = level); 0x08 PENDING (read; W1C for edge channels); 0x0C STATUS RO (PENDING & ENABLE); 0x10 SWSET (write-1-to-set pending, edge channels only; reads 0).
REQ-019 Valid access: HSEL & HREADY & HTRANS[1] in the address phase. The controller shall register HADDR[4:2] and HWRITE, and act in the following cycle (the data phase).
REQ-020 A write takes effect only when HSIZE = 3'b010 at the address phase; other sizes are accepted with OKAY and ignored.
REQ-021 Reads return the register value combinationally in the data phase.
REQ-022 Unmapped offsets read 0 and writes to them are ignored.
REQ-023 Register bits [31:NUM_SRC] read 0 and ignore writes.
REQ-024 Level channel: PENDING[i] shall equal the synchronised SRC[i], registered. W1C and SWSET have no effect on a level channel.
REQ-025 Edge channel: PENDING[i] shall set on a synchronised 0->1 transition or a SWSET bit, and clear on a W1C bit.
REQ-026 If set and clear hit the same bit in the same cycle, set wins.
REQ-027 Rising-edge detection shall compare the last sync stage with a delay flop.
REQ-028 A MODE change shall not itself generate an edge; the delay flop keeps tracking in both modes.
REQ-029 IRQ[i] shall be registered as PENDING[i] & ENABLE[i].
REQ-030 Latency: with SRC[i] high at clock edge 1, PENDING[i] is set at edge SYNC_STAGES+1 and IRQ[i] asserts at edge SYNC_STAGES+2.
REQ-031 A write to ENABLE or PENDING at the end of its data phase shall be reflected on IRQ one cycle later.
REQ-032 Back-to-back transfers, including a write followed by a read of the same register, shall complete with no stall; the read returns the newly written value.
REQ-033 An edge that occurs while ENABLE[i] = 0 shall still latch into PENDING[i]; IRQ[i] asserts when ENABLE[i] is later set.

Reset
REQ-034 HRESET high shall asynchronously clear ENABLE, MODE, PENDING, the sync chains, the delay flops, the address-phase registers and IRQ.
REQ-035 During reset, HRDATA = 0, HREADYOUT = 1 and HRESP = 0.
REQ-036 HRESET deasserted mid-transfer: the interrupted transfer shall be discarded.
REQ-037 After reset release, a source already high shall be treated as a 0->1 edge, because the delay flop resets to 0.

Verification
REQ-038 Write ENABLE = 0x1, MODE = 0x0; raise SRC[0] at edge 1 -> IRQ[0] = 1 at edge 4 (SYNC_STAGES = 2); drop SRC[0] -> IRQ[0] = 0 three cycles later.
REQ-039 MODE = 0x2, ENABLE = 0x2; pulse SRC[1] for 3 cycles -> PENDING reads 0x2 and stays set; write 0x2 to PENDING -> IRQ[1] = 0 next cycle.
REQ-040 Edge channel: a new SRC edge lands in the same cycle as a W1C on that bit -> PENDING bit remains 1.
REQ-041 Write SWSET = 0x3 with MODE = 0x1 -> PENDING = 0x1 (the level channel is unaffected); STATUS = PENDING & ENABLE.
REQ-042 NUM_SRC = 8: write 0xFFFFFFFF to ENABLE -> reads 0x000000FF; read offset 0x1C -> 0; a byte-size write is ignored.
REQ-043 Assert HRESET asynchronously while IRQ = 0xFF -> IRQ, ENABLE and PENDING all 0 immediately, with no clock edge required.
